// File: rtl/dbgpoke_pkg.sv
// dbgpoke_pkg
//   Shared definitions for the serial poke receiver:
//   - ASCII codes for the line terminators and the hex digit ranges.
//   - hex2nib(): classifies a received byte as a hex digit.
//   - rx_state_e: state encoding of the UART receiver FSM.
package dbgpoke_pkg;

  localparam logic [7:0] ASCII_NL   = 8'h0A;  // '\n'
  localparam logic [7:0] ASCII_CR   = 8'h0D;  // '\r'
  localparam logic [7:0] ASCII_0    = 8'h30;  // '0'
  localparam logic [7:0] ASCII_9    = 8'h39;  // '9'
  localparam logic [7:0] ASCII_UC_A = 8'h41;  // 'A'
  localparam logic [7:0] ASCII_UC_F = 8'h46;  // 'F'
  localparam logic [7:0] ASCII_LC_A = 8'h61;  // 'a'
  localparam logic [7:0] ASCII_LC_F = 8'h66;  // 'f'

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Returns {valid, nibble}; valid=0 (nibble=0) for anything that is not
  // a hex digit of either case.
  function automatic logic [4:0] hex2nib(input logic [7:0] b);
    logic [4:0] r;
    r = 5'b0;
    if (b >= ASCII_0 && b <= ASCII_9) begin
      r = {1'b1, 4'(b - ASCII_0)};
    end else if (b >= ASCII_LC_A && b <= ASCII_LC_F) begin
      r = {1'b1, 4'(b - ASCII_LC_A + 8'd10)};
    end else if (b >= ASCII_UC_A && b <= ASCII_UC_F) begin
      r = {1'b1, 4'(b - ASCII_UC_A + 8'd10)};
    end
    return r;
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_NL) || (b == ASCII_CR);
  endfunction

endpackage

// File: rtl/dbgpoke_uart_rx.sv
// uart_rx
//   8N1 UART receiver, counterpart of uart_tx.
//   Ports:
//     clk_i               clock
//     rst_i               synchronous active-low reset
//     clockcyclesperbit_i clk_i cycles per serial bit (>= 4)
//     rx_i                asynchronous serial input, idle high
//     data_o[7:0]         received byte, valid while valid_o is high
//     valid_o             one-cycle pulse: byte received with a good stop bit
//     ferr_o              one-cycle pulse: stop bit sampled low, byte dropped
module uart_rx
  import dbgpoke_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [CNTW-1:0] clockcyclesperbit_i,
  input  logic            rx_i,
  output logic [7:0]      data_o,
  output logic            valid_o,
  output logic            ferr_o
);

  // Two-flop synchronizer; rx_s is the only view of rx_i used below.
  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

  assign rx_s = sync_q[1];

  rx_state_e       state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  // Set after a low stop bit: the line has to be seen high again before a
  // falling level can be taken as a new start bit.
  logic            need_high_q, need_high_d;
  logic            expired;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      need_high_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      need_high_q <= need_high_d;
    end
  end

  // The counter is loaded with N-1 so that the sample happens N cycles
  // after the load.
  always_comb begin
    expired     = (cnt_q == '0);
    state_d     = state_q;
    cnt_d       = expired ? cnt_q : cnt_q - CNTW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;
    need_high_d = need_high_q;

    case (state_q)
      RX_IDLE: begin
        if (rx_s) begin
          need_high_d = 1'b0;
        end else if (!need_high_q) begin
          cnt_d   = (clockcyclesperbit_i >> 1) - CNTW'(1);
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (expired) begin
          if (!rx_s) begin
            cnt_d   = clockcyclesperbit_i - CNTW'(1);
            bit_d   = 3'd0;
            state_d = RX_DATA;
          end else begin
            // Too short to be a start bit: quietly ignore it.
            state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (expired) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = clockcyclesperbit_i - CNTW'(1);
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (expired) begin
          if (rx_s) begin
            valid_d = 1'b1;
          end else begin
            ferr_d      = 1'b1;
            need_high_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data_o  = shift_q;
  assign valid_o = valid_q;
  assign ferr_o  = ferr_q;

endmodule

// File: rtl/dbgpoke.sv
// dbgpoke
//   Receives ASCII hex lines (MSB first, terminated by '\n' or '\r') over an
//   8N1 serial line and commits each completed line to poke_o.
//   Ports:
//     clk_i   clock
//     rst_i   synchronous active-low reset
//     rx_i    asynchronous serial input, idle high
//     poke_o  last committed value (held between commits)
//     stb_o   one-cycle pulse when poke_o is updated
//     err_o   one-cycle pulse on a framing error or an illegal character
//     busy_o  a line is partially received (digits pending or discarding)
module dbgpoke
  import dbgpoke_pkg::*;
#(
  parameter int CLKFREQ   = 1,
  parameter int POKEWIDTH = 1,
  parameter int RXBITRATE = 115200
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [POKEWIDTH-1:0] poke_o,
  output logic                 stb_o,
  output logic                 err_o,
  output logic                 busy_o
);

  localparam int CLKS     = CLKFREQ / RXBITRATE;
  localparam int CNTW     = (CLKS < 4) ? 3 : $clog2(CLKS + 1);
  // Digits needed to fill the value; one more marks "overflowed".
  localparam int NDIG     = (POKEWIDTH + 3) / 4;
  localparam int DCNT_MAX = NDIG + 1;
  localparam int DCW      = $clog2(DCNT_MAX + 1);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(
    .CNTW(CNTW)
  ) u_uart_rx (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .clockcyclesperbit_i(CNTW'(CLKS)),
    .rx_i               (rx_i),
    .data_o             (rx_data),
    .valid_o            (rx_valid),
    .ferr_o             (rx_ferr)
  );

  logic [POKEWIDTH-1:0] acc_q, acc_d;
  logic [POKEWIDTH-1:0] poke_q, poke_d;
  logic [DCW-1:0]       dcnt_q, dcnt_d;
  logic                 disc_q, disc_d;
  logic                 stb_q, stb_d;
  logic                 err_q, err_d;
  logic [4:0]           nib;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc_q  <= '0;
      poke_q <= '0;
      dcnt_q <= '0;
      disc_q <= 1'b0;
      stb_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      poke_q <= poke_d;
      dcnt_q <= dcnt_d;
      disc_q <= disc_d;
      stb_q  <= stb_d;
      err_q  <= err_d;
    end
  end

  // A framing error never coincides with rx_valid, so stb and err can
  // never be raised together.
  always_comb begin
    acc_d  = acc_q;
    poke_d = poke_q;
    dcnt_d = dcnt_q;
    disc_d = disc_q;
    stb_d  = 1'b0;
    err_d  = rx_ferr;
    nib    = hex2nib(rx_data);

    if (rx_valid) begin
      if (is_term(rx_data)) begin
        // Empty lines (e.g. the second half of "\n\r") commit nothing.
        if (!disc_q && dcnt_q != '0) begin
          poke_d = acc_q;
          stb_d  = 1'b1;
        end
        acc_d  = '0;
        dcnt_d = '0;
        disc_d = 1'b0;
      end else if (nib[4]) begin
        // While discarding, digits are swallowed and acc stays frozen.
        if (!disc_q) begin
          acc_d = POKEWIDTH'({acc_q, nib[3:0]});
          if (dcnt_q != DCW'(DCNT_MAX)) begin
            dcnt_d = dcnt_q + DCW'(1);
          end
        end
      end else begin
        err_d  = 1'b1;
        disc_d = 1'b1;
      end
    end
  end

  assign poke_o = poke_q;
  assign stb_o  = stb_q;
  assign err_o  = err_q;
  assign busy_o = (dcnt_q != '0) || disc_q;

endmodule

// File: tb/tb_dbgpoke.sv
module tb_dbgpoke;

  localparam int CLKFREQ   = 1600000;
  localparam int RXBITRATE = 100000;
  localparam int POKEWIDTH = 12;
  localparam int CLKS      = CLKFREQ / RXBITRATE;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b0;
  logic                 rx_i = 1'b1;
  logic [POKEWIDTH-1:0] poke_o;
  logic                 stb_o;
  logic                 err_o;
  logic                 busy_o;

  dbgpoke #(
    .CLKFREQ  (CLKFREQ),
    .POKEWIDTH(POKEWIDTH),
    .RXBITRATE(RXBITRATE)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .rx_i  (rx_i),
    .poke_o(poke_o),
    .stb_o (stb_o),
    .err_o (err_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_start = 0;

  // Observations
  int obs_q[$];
  int stb_cyc[$];
  int obs_err = 0;
  int overlap = 0;

  // Reference model: plain line arithmetic
  int exp_q[$];
  int exp_err = 0;
  int m_acc = 0;
  int m_cnt = 0;
  bit m_disc = 1'b0;
  int m_poke = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (stb_o) begin
      obs_q.push_back(int'(poke_o));
      stb_cyc.push_back(cyc);
    end
    if (err_o) obs_err <= obs_err + 1;
    if (stb_o && err_o) overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "a" && b <= "f") return int'(b) - 97 + 10;
    if (b >= "A" && b <= "F") return int'(b) - 65 + 10;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int v;
    v = hexval(b);
    if (b == 8'h0A || b == 8'h0D) begin
      if (!m_disc && m_cnt > 0) begin
        exp_q.push_back(m_acc);
        m_poke = m_acc;
      end
      m_acc = 0; m_cnt = 0; m_disc = 1'b0;
    end else if (v >= 0) begin
      if (!m_disc) begin
        m_acc = (m_acc * 16 + v) % (1 << POKEWIDTH);
        m_cnt = m_cnt + 1;
      end
    end else begin
      exp_err = exp_err + 1;
      m_disc = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_disc = 1'b0; m_poke = 0;
  endtask

  task automatic bit_period();
    repeat (CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1;
    rx_i = 1'b0;
    last_start = cyc;
    bit_period();
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      bit_period();
    end
    rx_i = stop;
    bit_period();
    rx_i = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    send_frame(b, 1'b1);
    model_byte(b);
    @(negedge clk);
    check($sformatf("busy after 0x%02h", b), busy_o, (m_cnt > 0 || m_disc) ? 1 : 0);
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], $urandom_range(0, 8));
    end
  endtask

  task automatic end_scenario(input string name);
    int n;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check({name, " stb count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s poke[%0d]", name, i), obs_q[i], exp_q[i]);
    end
    check({name, " err count"}, obs_err, exp_err);
    check({name, " poke hold"}, poke_o, m_poke);
    $display("scenario %s: %0d commits, %0d errors", name, obs_q.size(), obs_err);
    obs_q.delete();
    exp_q.delete();
    stb_cyc.delete();
    obs_err = 0;
    exp_err = 0;
  endtask

  initial begin
    int d;
    string s;
    int len;
    int v;

    // Reset state
    rst_i = 1'b0;
    rx_i  = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset poke", poke_o, 0);
    check("reset stb", stb_o, 0);
    check("reset err", err_o, 0);
    check("reset busy", busy_o, 0);
    #1;
    rst_i = 1'b1;
    repeat (10) @(posedge clk);

    // 1: "a5C\n\r" commits once, latency check on the '\n'
    send_str("a5C");
    send_byte(8'h0A, 0);
    d = last_start;
    send_byte(8'h0D, 5);
    repeat (30) @(posedge clk);
    if (stb_cyc.size() > 0) begin
      check("stb latency window", (stb_cyc[0] - d >= 150 && stb_cyc[0] - d <= 162) ? 1 : 0, 1);
    end else begin
      check("stb latency seen", 0, 1);
    end
    end_scenario("a5C");

    // 2: overflow keeps low bits
    send_str("12345\n");
    end_scenario("12345");

    // 3: illegal char discards the line
    send_str("1g3\n7\n");
    end_scenario("1g3_7");

    // 4: framing error drops the byte
    send_frame(8'h31, 1'b0);
    exp_err = exp_err + 1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("busy after ferr", busy_o, 0);
    send_str("2\n");
    end_scenario("ferr");

    // 5: short glitch while idle
    @(posedge clk);
    #1;
    rx_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx_i = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("glitch err", obs_err, 0);
    check("glitch stb", obs_q.size(), 0);
    send_str("f\n");
    end_scenario("glitch");

    // 6: reset in the middle of a byte
    send_str("ab");
    @(posedge clk);
    #1;
    rx_i = 1'b0;          // start bit of 'c'
    bit_period();
    rx_i = 1'b1;          // bit0 of 'c' (0x63) is 1
    repeat (5) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(negedge clk);
    check("midreset poke", poke_o, 0);
    check("midreset busy", busy_o, 0);
    check("midreset stb", stb_o, 0);
    model_reset();
    repeat (200) @(posedge clk);
    send_str("c\n");
    end_scenario("midreset");

    // 7: random lines against the model
    for (int ln = 0; ln < 10; ln++) begin
      s = "";
      if ($urandom_range(0, 7) == 0) s = {s, "\n"};
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 3))
            0: s = {s, "g"};
            1: s = {s, "x"};
            2: s = {s, " "};
            default: s = {s, "-"};
          endcase
        end else begin
          v = $urandom_range(0, 15);
          if (v < 10) s = {s, string'(8'(48 + v))};
          else if ($urandom_range(0, 1) == 1) s = {s, string'(8'(65 + v - 10))};
          else s = {s, string'(8'(97 + v - 10))};
        end
      end
      if ($urandom_range(0, 1) == 1) s = {s, "\n"};
      else s = {s, "\r"};
      if ($urandom_range(0, 2) == 0) s = {s, "\r"};
      send_str(s);
      end_scenario($sformatf("rand%0d", ln));
    end

    check("stb/err overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
